aoi222_rr_sel_ctrl: RTL and testbench
=====================================

Name: aoi222_rr_sel_ctrl

Overview:
Sequential select controller for a WIDTH-bit 3:1 data mux built from an aoi222 bank.
- Upstream side: data bit i of sources A/B/C drives A1/B1/C1 of slice i. This block arbitrates three requesters round-robin and drives the one-hot select legs (A2/B2/C2, shared by all slices).
- Downstream side: captures the bank's inverted ZN bus, waits a programmable settle time first, and presents the re-inverted word over a VALID/READY handshake.

Parameters:
- WIDTH, 8, data bus width (number of aoi222 slices); range 1..64.
- SETTLE, 1, extra cycles SEL is held before capture; range 0..15.

Ports:
- CLK  input  1  rising-edge clock.
- RN  input  1  synchronous active-low reset, sampled on CLK rising edge.
- REQ  input  3  level requests: [0]=source A, [1]=source B, [2]=source C.
- ACK  output  3  one-cycle grant-complete pulse to the granted source.
- SEL  output  3  one-hot select to A2/B2/C2 legs ([0]=A2, [1]=B2, [2]=C2); 3'b000 when not selecting.
- ZN  input  WIDTH  inverted mux result from the aoi222 bank.
- Q  output  WIDTH  captured data, equal to ~ZN at the capture edge.
- VALID  output  1  Q holds a word not yet accepted.
- READY  input  1  downstream accepts Q when VALID && READY.
- BUSY  output  1  high whenever FSM is not IDLE.

Behaviour:
- Reset (RN=0 at an edge): SEL=0, ACK=0, Q=0, VALID=0, BUSY=0, FSM=IDLE, last-granted pointer=C (so A wins first). Reset has priority over every other event, including mid-SETTLE and mid-HOLD.
- State IDLE:
  - REQ!=0: pick the first requester after last-granted in order A->B->C->A.
  - Register SEL=onehot(g) and cnt=SETTLE; go to SETTLE.
  - REQ==0: stay.
- State SETTLE:
  - SEL held constant.
  - cnt!=0: cnt decrements.
  - cnt==0 (same edge): Q<=~ZN, VALID<=1, ACK[g]<=1 for exactly one cycle, SEL<=0, last-granted<=g; go to HOLD.
  - SEL is high for SETTLE+1 cycles.
  - Latency from the IDLE edge that samples REQ to VALID high is SETTLE+2 edges.
- State HOLD:
  - VALID=1, Q stable, SEL=0, no new arbitration.
  - On an edge with READY=1: VALID<=0. If REQ!=0 on that edge, arbitrate immediately (SEL asserted the next cycle, state SETTLE); otherwise go to IDLE.
- ACK rises on the same edge as VALID. The granted source must hold REQ and data until ACK.
- REQ deasserted before ACK: transfer still completes and ACK still pulses. No revocation.
- REQ bits of non-granted sources are ignored outside arbitration edges.
- SEL is always one-hot or zero, never multi-hot. With SEL=0 the bank outputs ZN all-ones, which is never captured.
- Counter width: max(1, clog2(SETTLE+1)); no wrap beyond SETTLE.
- ZN is captured verbatim: X/Z on ZN propagates to Q.
- Throughput under continuous REQ and READY=1: one word per SETTLE+2 cycles.

Optional Feature:
- Macro: AOI222_RR_SEL_FIXED_PRIO_EN.
- Defined: arbitration is fixed priority A>B>C. The last-granted pointer is not implemented and has no effect.
- Undefined: round-robin exactly as described above.
- Ports, timing, and handshake are identical in both builds.

Test Plan:
1. RN=0 for 2 edges with REQ=111, READY=1 -> SEL=000, ACK=000, Q=0, VALID=0, BUSY=0 after the first reset edge.
2. SETTLE=1, REQ=001 from edge 0, ZN=8'h5A held -> SEL=001 after edges 1-2; at edge 3 Q=8'hA5, VALID=1, ACK=001 for one cycle, SEL=000.
3. SETTLE=0, REQ=111 held, READY=1 -> SEL sequence 001,010,100,001 and ACK sequence A,B,C,A, one word every 2 cycles.
4. READY=0 for 5 cycles after VALID with REQ=010 pending -> VALID, Q held and SEL=000 throughout; READY=1 -> VALID drops and SEL=010 on the following cycle.
5. RN=0 for one edge while SEL=010 in SETTLE -> SEL=000 and VALID=0 next cycle, no ACK; then REQ=111 -> A granted first.
6. Macro defined, REQ=111 held, READY=1 -> every grant is A (SEL=001 each transfer); B and C never acknowledged.

Source files
------------

// File: rtl/aoi222_rr_sel_ctrl_if.sv
// Bus bundle between the aoi222 select controller, its three requesters,
// the aoi222 bank output and the downstream consumer.
interface aoi222_rr_sel_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [2:0]       REQ;    // level requests: [0]=A, [1]=B, [2]=C
  logic [2:0]       ACK;    // one-cycle grant-complete pulse
  logic [2:0]       SEL;    // one-hot select to A2/B2/C2 legs
  logic [WIDTH-1:0] ZN;     // inverted mux result from the bank
  logic [WIDTH-1:0] Q;      // captured, re-inverted word
  logic             VALID;  // Q holds a word not yet accepted
  logic             READY;  // downstream accepts Q when VALID && READY
  logic             BUSY;   // controller is not idle

  // Controller side
  modport master (
    input  REQ, ZN, READY,
    output ACK, SEL, Q, VALID, BUSY
  );

  // Requesters / bank / consumer side
  modport slave (
    output REQ, ZN, READY,
    input  ACK, SEL, Q, VALID, BUSY
  );
endinterface

// File: rtl/aoi222_rr_sel_ctrl.sv
// Select controller for a WIDTH-bit 3:1 mux built from an aoi222 bank.
// Arbitrates three requesters, drives the shared one-hot select legs, holds
// the select for SETTLE+1 cycles, then captures ~ZN and offers it over a
// VALID/READY handshake.
// Build option: define AOI222_RR_SEL_FIXED_PRIO_EN for fixed priority A>B>C
// instead of round-robin; ports and timing are unchanged.
module aoi222_rr_sel_ctrl #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input logic                  CLK,
  input logic                  RN,
  aoi222_rr_sel_ctrl_if.master bus
);

  localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_HOLD
  } state_t;

  state_t           r_state, w_state_next;
  logic [2:0]       r_sel, w_sel_next;
  logic [2:0]       r_ack, w_ack_next;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic [WIDTH-1:0] r_q, w_q_next;
  logic             r_valid, w_valid_next;
  logic [2:0]       w_grant;

`ifdef AOI222_RR_SEL_FIXED_PRIO_EN
  // Fixed priority A > B > C; no memory of previous grants.
  always_comb begin
    w_grant = 3'b000;
    if (bus.REQ[0])      w_grant = 3'b001;
    else if (bus.REQ[1]) w_grant = 3'b010;
    else if (bus.REQ[2]) w_grant = 3'b100;
  end
`else
  // One-hot last-granted pointer; resets to C so that A wins first.
  logic [2:0] r_last, w_last_next;

  // Round-robin: search starts at the source after the last grant.
  always_comb begin
    w_grant = 3'b000;
    case (r_last)
      3'b001: begin
        if (bus.REQ[1])      w_grant = 3'b010;
        else if (bus.REQ[2]) w_grant = 3'b100;
        else if (bus.REQ[0]) w_grant = 3'b001;
      end
      3'b010: begin
        if (bus.REQ[2])      w_grant = 3'b100;
        else if (bus.REQ[0]) w_grant = 3'b001;
        else if (bus.REQ[1]) w_grant = 3'b010;
      end
      default: begin
        if (bus.REQ[0])      w_grant = 3'b001;
        else if (bus.REQ[1]) w_grant = 3'b010;
        else if (bus.REQ[2]) w_grant = 3'b100;
      end
    endcase
  end
`endif

  // Next-state and datapath decisions; r_sel doubles as the held grant.
  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    w_ack_next   = 3'b000;
    w_cnt_next   = r_cnt;
    w_q_next     = r_q;
    w_valid_next = r_valid;
`ifndef AOI222_RR_SEL_FIXED_PRIO_EN
    w_last_next  = r_last;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.REQ != 3'b000) begin
          w_sel_next   = w_grant;
          w_cnt_next   = SETTLE_LOAD;
          w_state_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - CW'(1);
        end else begin
          w_q_next     = ~bus.ZN;
          w_valid_next = 1'b1;
          w_ack_next   = r_sel;
          w_sel_next   = 3'b000;
`ifndef AOI222_RR_SEL_FIXED_PRIO_EN
          w_last_next  = r_sel;
`endif
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.READY) begin
          w_valid_next = 1'b0;
          if (bus.REQ != 3'b000) begin
            w_sel_next   = w_grant;
            w_cnt_next   = SETTLE_LOAD;
            w_state_next = S_SETTLE;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_sel_next   = 3'b000;
      end
    endcase
  end

  // State register with synchronous active-low reset taking priority.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_state <= S_IDLE;
      r_sel   <= 3'b000;
      r_ack   <= 3'b000;
      r_cnt   <= '0;
      r_q     <= '0;
      r_valid <= 1'b0;
`ifndef AOI222_RR_SEL_FIXED_PRIO_EN
      r_last  <= 3'b100;
`endif
    end else begin
      r_state <= w_state_next;
      r_sel   <= w_sel_next;
      r_ack   <= w_ack_next;
      r_cnt   <= w_cnt_next;
      r_q     <= w_q_next;
      r_valid <= w_valid_next;
`ifndef AOI222_RR_SEL_FIXED_PRIO_EN
      r_last  <= w_last_next;
`endif
    end
  end

  assign bus.SEL   = r_sel;
  assign bus.ACK   = r_ack;
  assign bus.Q     = r_q;
  assign bus.VALID = r_valid;
  assign bus.BUSY  = (r_state != S_IDLE);

endmodule

// File: tb/tb_aoi222_rr_sel_ctrl.sv
// Bench for aoi222_rr_sel_ctrl: two instances (SETTLE=1 and SETTLE=0), each
// fed by a behavioural aoi222 bank. Expected grants/words go into a queue
// when requests are driven and are popped when ACK appears.
module tb_aoi222_rr_sel_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic [2:0]   src;
    logic [W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rn;
  logic mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] da1, db1, dc1, da0, db0, dc0;
  exp_t q1[$];
  exp_t q0[$];
  exp_t e1, e0;

  aoi222_rr_sel_ctrl_if #(.WIDTH(W)) if1 ();
  aoi222_rr_sel_ctrl_if #(.WIDTH(W)) if0 ();

  aoi222_rr_sel_ctrl #(.WIDTH(W), .SETTLE(1)) u_dut1 (.CLK(clk), .RN(rn), .bus(if1));
  aoi222_rr_sel_ctrl #(.WIDTH(W), .SETTLE(0)) u_dut0 (.CLK(clk), .RN(rn), .bus(if0));

  // Behavioural aoi222 banks: ZN = ~(A1&A2 | B1&B2 | C1&C2) per slice
  assign if1.ZN = ~((da1 & {W{if1.SEL[0]}}) | (db1 & {W{if1.SEL[1]}}) | (dc1 & {W{if1.SEL[2]}}));
  assign if0.ZN = ~((da0 & {W{if0.SEL[0]}}) | (db0 & {W{if0.SEL[1]}}) | (dc0 & {W{if0.SEL[2]}}));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [2:0] src, input logic [W-1:0] data);
    exp_t e;
    e.src = src;
    e.data = data;
    q1.push_back(e);
  endtask

  task automatic push0(input logic [2:0] src, input logic [W-1:0] data);
    exp_t e;
    e.src = src;
    e.data = data;
    q0.push_back(e);
  endtask

  // Scoreboard for the SETTLE=1 instance
  always @(negedge clk) begin
    if (mon_en && if1.ACK != 3'b000) begin
      if (q1.size() == 0) begin
        check("sb1_unexpected_ack", {61'd0, if1.ACK}, 64'd0);
      end else begin
        e1 = q1.pop_front();
        check("sb1_ack", {61'd0, if1.ACK}, {61'd0, e1.src});
        check("sb1_q", {56'd0, if1.Q}, {56'd0, e1.data});
        $display("dut1 xfer ack=%b q=%h", if1.ACK, if1.Q);
      end
    end
  end

  // Scoreboard for the SETTLE=0 instance
  always @(negedge clk) begin
    if (mon_en && if0.ACK != 3'b000) begin
      if (q0.size() == 0) begin
        check("sb0_unexpected_ack", {61'd0, if0.ACK}, 64'd0);
      end else begin
        e0 = q0.pop_front();
        check("sb0_ack", {61'd0, if0.ACK}, {61'd0, e0.src});
        check("sb0_q", {56'd0, if0.Q}, {56'd0, e0.data});
        $display("dut0 xfer ack=%b q=%h", if0.ACK, if0.Q);
      end
    end
  end

  initial begin
    int n;
    logic [2:0] sel_tab [8];
`ifdef AOI222_RR_SEL_FIXED_PRIO_EN
    sel_tab = '{3'b001, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000};
`else
    sel_tab = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
`endif
    rn = 1'b0;
    if1.REQ = 3'b111; if1.READY = 1'b1;
    if0.REQ = 3'b111; if0.READY = 1'b1;
    da1 = '0; db1 = '0; dc1 = '0;
    da0 = '0; db0 = '0; dc0 = '0;

    // Reset with all requests asserted
    tick();
    mon_en = 1'b1;
    check("rst_sel", {61'd0, if1.SEL}, 64'd0);
    check("rst_ack", {61'd0, if1.ACK}, 64'd0);
    check("rst_q", {56'd0, if1.Q}, 64'd0);
    check("rst_valid", {63'd0, if1.VALID}, 64'd0);
    check("rst_busy", {63'd0, if1.BUSY}, 64'd0);
    check("rst0_sel", {61'd0, if0.SEL}, 64'd0);
    tick();
    check("rst2_busy", {63'd0, if1.BUSY}, 64'd0);
    rn = 1'b1; if1.REQ = 3'b000; if0.REQ = 3'b000;
    tick();
    check("idle_busy", {63'd0, if1.BUSY}, 64'd0);

    // Single request from A, SETTLE=1
    da1 = 8'hA5; if1.REQ = 3'b001; push1(3'b001, 8'hA5);
    tick();
    check("t2_sel_a", {61'd0, if1.SEL}, 64'd1);
    check("t2_busy", {63'd0, if1.BUSY}, 64'd1);
    tick();
    check("t2_sel_held", {61'd0, if1.SEL}, 64'd1);
    check("t2_valid_low", {63'd0, if1.VALID}, 64'd0);
    tick();
    check("t2_sel_off", {61'd0, if1.SEL}, 64'd0);
    check("t2_valid", {63'd0, if1.VALID}, 64'd1);
    if1.REQ = 3'b000;
    tick();
    check("t2_ack_pulse", {61'd0, if1.ACK}, 64'd0);
    check("t2_valid_drop", {63'd0, if1.VALID}, 64'd0);
    check("t2_idle", {63'd0, if1.BUSY}, 64'd0);

    // Back-pressure: READY low while B waits
    if1.READY = 1'b0; da1 = 8'h3C; if1.REQ = 3'b001; push1(3'b001, 8'h3C);
    tick(); tick(); tick();
    check("t4_cap_valid", {63'd0, if1.VALID}, 64'd1);
    if1.REQ = 3'b010; db1 = 8'h96; push1(3'b010, 8'h96);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_valid", {63'd0, if1.VALID}, 64'd1);
      check("t4_hold_q", {56'd0, if1.Q}, 64'h3C);
      check("t4_hold_sel", {61'd0, if1.SEL}, 64'd0);
      check("t4_hold_ack", {61'd0, if1.ACK}, 64'd0);
    end
    if1.READY = 1'b1;
    tick();
    check("t4_valid_drop", {63'd0, if1.VALID}, 64'd0);
    check("t4_sel_b", {61'd0, if1.SEL}, 64'd2);

    // Reset in the middle of SETTLE: B's transfer is abandoned
    rn = 1'b0;
    tick();
    rn = 1'b1;
    check("t5_sel", {61'd0, if1.SEL}, 64'd0);
    check("t5_valid", {63'd0, if1.VALID}, 64'd0);
    check("t5_busy", {63'd0, if1.BUSY}, 64'd0);
    check("t5_q", {56'd0, if1.Q}, 64'd0);
    q1.delete(q1.size() - 1);
    da1 = 8'h11; db1 = 8'h22; dc1 = 8'h33; if1.REQ = 3'b111;
`ifdef AOI222_RR_SEL_FIXED_PRIO_EN
    push1(3'b001, 8'h11); push1(3'b001, 8'h11); push1(3'b001, 8'h11); push1(3'b001, 8'h11);
`else
    push1(3'b001, 8'h11); push1(3'b010, 8'h22); push1(3'b100, 8'h33); push1(3'b001, 8'h11);
`endif
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      tick();
      if (if1.ACK != 3'b000) n++;
      if (n == 4) if1.REQ = 3'b000;
    end
    check("t5_ack_count", 64'(n), 64'd4);
    tick();
    check("t5_idle", {63'd0, if1.BUSY}, 64'd0);

    // SETTLE=0: continuous requests, one word every two cycles
    da0 = 8'hC1; db0 = 8'hD2; dc0 = 8'hE3; if0.REQ = 3'b111;
`ifdef AOI222_RR_SEL_FIXED_PRIO_EN
    push0(3'b001, 8'hC1); push0(3'b001, 8'hC1); push0(3'b001, 8'hC1); push0(3'b001, 8'hC1);
`else
    push0(3'b001, 8'hC1); push0(3'b010, 8'hD2); push0(3'b100, 8'hE3); push0(3'b001, 8'hC1);
`endif
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t3_sel", {61'd0, if0.SEL}, {61'd0, sel_tab[i]});
      check("t3_valid", {63'd0, if0.VALID}, {63'd0, i[0]});
      if (i == 6) if0.REQ = 3'b000;
    end
    tick();
    check("t3_idle", {63'd0, if0.BUSY}, 64'd0);

    // Request withdrawn before ACK still completes
    if0.REQ = 3'b100; push0(3'b100, 8'hE3);
    tick();
    check("t7_sel_c", {61'd0, if0.SEL}, 64'd4);
    if0.REQ = 3'b000;
    tick();
    check("t7_valid", {63'd0, if0.VALID}, 64'd1);
    tick();
    check("t7_idle", {63'd0, if0.BUSY}, 64'd0);

    tick();
    check("sb1_drained", 64'(q1.size()), 64'd0);
    check("sb0_drained", 64'(q0.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
